// File: rtl/msrh_pkg.sv
// rtl/msrh_pkg.sv - shared types for the integer issue path
package msrh_pkg;
    localparam int TGT_BUS_SIZE = 2;
    localparam int RNID_W       = 6;
    localparam int XLEN         = 32;

    typedef enum logic {
        GPR = 1'b0,
        FPR = 1'b1
    } reg_t;

    typedef struct packed {
        logic              valid;
        logic [31:0]       inst;
        logic [XLEN-1:0]   pc_addr;
        logic              rd_valid;
        reg_t              rd_type;
        logic [RNID_W-1:0] rd_rnid;
        logic              rs1_valid;
        reg_t              rs1_type;
        logic [RNID_W-1:0] rs1_rnid;
        logic              rs1_pred_ready;
        logic              rs2_valid;
        reg_t              rs2_type;
        logic [RNID_W-1:0] rs2_rnid;
        logic              rs2_pred_ready;
    } issue_t;

    typedef struct packed {
        logic              valid;
        reg_t              rd_type;
        logic [RNID_W-1:0] rd_rnid;
    } phy_wr_t;
endpackage

// File: rtl/msrh_done_if.sv
// rtl/msrh_done_if.sv - completion report from the ALU pipe back to its issue unit
interface msrh_done_if #(parameter int ENTRY_SIZE = 8);
    logic                  done;
    logic [ENTRY_SIZE-1:0] index_oh;
    logic                  except_valid;
    logic [3:0]            except_type;

    modport master (output done, index_oh, except_valid, except_type);
    modport slave  (input  done, index_oh, except_valid, except_type);
endinterface

// File: rtl/msrh_alu_issue_unit_age.sv
// rtl/msrh_alu_issue_unit_age.sv - age matrix picking the oldest requesting entry
module msrh_age_matrix #(
    parameter int ENTRY_SIZE = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_flush,
    input  logic [ENTRY_SIZE-1:0] i_alloc_oh,
    input  logic [ENTRY_SIZE-1:0] i_free,
    input  logic [ENTRY_SIZE-1:0] i_req,
    output logic [ENTRY_SIZE-1:0] o_oldest_oh
);
    // older_q[i][j] = 1 means entry j was allocated before entry i
    logic [ENTRY_SIZE-1:0] older_q [ENTRY_SIZE];
    logic [ENTRY_SIZE-1:0] older_d [ENTRY_SIZE];

    always_comb begin
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            for (int j = 0; j < ENTRY_SIZE; j++) begin
                older_d[i][j] = older_q[i][j];
                if (i_free[i] || i_free[j]) older_d[i][j] = 1'b0;
                if (i_alloc_oh[i])          older_d[i][j] = (i != j);
                else if (i_alloc_oh[j])     older_d[i][j] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < ENTRY_SIZE; i++) older_q[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < ENTRY_SIZE; i++) older_q[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRY_SIZE; i++) older_q[i] <= older_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRY_SIZE; i++)
            o_oldest_oh[i] = i_req[i] & ~(|(i_req & older_q[i]));
    end
endmodule

// File: rtl/msrh_alu_issue_unit.sv
// rtl/msrh_alu_issue_unit.sv - reservation station feeding one ALU pipe
module msrh_alu_issue_unit
    import msrh_pkg::*;
#(
    parameter int ENTRY_SIZE = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_flush_valid,
    input  logic                  i_disp_valid,
    input  issue_t                i_disp_issue,
    output logic                  o_disp_ready,
    input  phy_wr_t               i_phy_wr [TGT_BUS_SIZE],
    input  logic                  i_muldiv_stall,
    output issue_t                o_issue,
    output logic [ENTRY_SIZE-1:0] o_issue_index,
    msrh_done_if.slave            done_if
);
    typedef enum logic [1:0] {FREE, WAIT, READY, ISSUED} state_t;

    state_t                state_q   [ENTRY_SIZE];
    issue_t                entry_q   [ENTRY_SIZE];
    logic [ENTRY_SIZE-1:0] rs1_rdy_q, rs2_rdy_q;
    logic [ENTRY_SIZE-1:0] free_vec, ready_vec, issued_vec;
    logic [ENTRY_SIZE-1:0] alloc_oh, done_oh, req_vec, grant_oh;
    logic [ENTRY_SIZE-1:0] rs1_wake, rs2_wake;
    logic                  disp_fire, disp_rs1_rdy, disp_rs2_rdy;
    issue_t                sel_issue;
    logic                  unused_done_except;

    function automatic logic wake_hit(input reg_t t, input logic [RNID_W-1:0] rnid);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < TGT_BUS_SIZE; k++)
            hit |= i_phy_wr[k].valid && (i_phy_wr[k].rd_type == t) && (i_phy_wr[k].rd_rnid == rnid);
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < ENTRY_SIZE; i++) begin
            free_vec[i]   = (state_q[i] == FREE);
            ready_vec[i]  = (state_q[i] == READY);
            issued_vec[i] = (state_q[i] == ISSUED);
            rs1_wake[i]   = rs1_rdy_q[i] | wake_hit(entry_q[i].rs1_type, entry_q[i].rs1_rnid);
            rs2_wake[i]   = rs2_rdy_q[i] | wake_hit(entry_q[i].rs2_type, entry_q[i].rs2_rnid);
        end
    end

    // Ready is derived from registered state only, so a slot freed this cycle is not offered yet
    assign o_disp_ready = |free_vec;
    assign disp_fire    = i_disp_valid & o_disp_ready & ~i_flush_valid;
    assign alloc_oh     = disp_fire ? (free_vec & (~free_vec + 1'b1)) : '0;
    assign done_oh      = {ENTRY_SIZE{done_if.done}} & done_if.index_oh & issued_vec;
    assign req_vec      = ready_vec & {ENTRY_SIZE{~i_muldiv_stall}};

    assign disp_rs1_rdy = !i_disp_issue.rs1_valid || (i_disp_issue.rs1_rnid == '0) ||
                          wake_hit(i_disp_issue.rs1_type, i_disp_issue.rs1_rnid);
    assign disp_rs2_rdy = !i_disp_issue.rs2_valid || (i_disp_issue.rs2_rnid == '0) ||
                          wake_hit(i_disp_issue.rs2_type, i_disp_issue.rs2_rnid);

    assign unused_done_except = ^{done_if.except_valid, done_if.except_type};

    msrh_age_matrix #(.ENTRY_SIZE(ENTRY_SIZE)) u_age (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_flush     (i_flush_valid),
        .i_alloc_oh  (alloc_oh),
        .i_free      (done_oh),
        .i_req       (req_vec),
        .o_oldest_oh (grant_oh)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                state_q[i] <= FREE;
                entry_q[i] <= '0;
            end
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
        end else if (i_flush_valid) begin
            for (int i = 0; i < ENTRY_SIZE; i++) state_q[i] <= FREE;
        end else begin
            for (int i = 0; i < ENTRY_SIZE; i++) begin
                case (state_q[i])
                    FREE: if (alloc_oh[i]) begin
                        entry_q[i]   <= i_disp_issue;
                        rs1_rdy_q[i] <= disp_rs1_rdy;
                        rs2_rdy_q[i] <= disp_rs2_rdy;
                        state_q[i]   <= (disp_rs1_rdy && disp_rs2_rdy) ? READY : WAIT;
                    end
                    WAIT: begin
                        rs1_rdy_q[i] <= rs1_wake[i];
                        rs2_rdy_q[i] <= rs2_wake[i];
                        if (rs1_wake[i] && rs2_wake[i]) state_q[i] <= READY;
                    end
                    READY:   if (grant_oh[i]) state_q[i] <= ISSUED;
                    ISSUED:  if (done_oh[i])  state_q[i] <= FREE;
                    default: state_q[i] <= FREE;
                endcase
            end
        end
    end

    always_comb begin
        sel_issue = '0;
        for (int i = 0; i < ENTRY_SIZE; i++)
            if (grant_oh[i]) sel_issue = issue_t'(sel_issue | entry_q[i]);
        sel_issue.valid          = 1'b1;
        sel_issue.rs1_pred_ready = 1'b0;
        sel_issue.rs2_pred_ready = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_issue       <= '0;
            o_issue_index <= '0;
        end else if (i_flush_valid || (grant_oh == '0)) begin
            o_issue       <= '0;
            o_issue_index <= '0;
        end else begin
            o_issue       <= sel_issue;
            o_issue_index <= grant_oh;
        end
    end

`ifdef SIMULATION
    always_ff @(posedge i_clk) begin
        if (i_reset_n && i_disp_valid && !o_disp_ready)
            $fatal(1, "dispatch while issue unit is full");
        if (i_reset_n && done_if.done && ((done_if.index_oh & ~issued_vec) != '0))
            $error("done index hits a non-issued entry");
    end
`endif
endmodule
